// File: rtl/l1_cache_pkg.sv
// Shared types and load/store lane helpers for the parametrised L1 data cache.
package l1_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] MASK_LB  = 3'b000;
    localparam logic [2:0] MASK_LH  = 3'b001;
    localparam logic [2:0] MASK_LW  = 3'b010;
    localparam logic [2:0] MASK_LBU = 3'b100;
    localparam logic [2:0] MASK_LHU = 3'b101;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_lane_t;

    // Halfword accesses use addr[1] only; addr[0] is ignored.
    function automatic logic [31:0] load_extract(input logic [2:0]  mask,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (mask)
            MASK_LB:  return {{24{b[7]}}, b};
            MASK_LH:  return {{16{h[15]}}, h};
            MASK_LW:  return word;
            MASK_LBU: return {24'b0, b};
            MASK_LHU: return {16'b0, h};
            default:  return 32'b0;
        endcase
    endfunction

    // Unsupported store masks produce no enabled lanes but still go to memory.
    function automatic store_lane_t store_lanes(input logic [2:0]  mask,
                                                input logic [1:0]  off,
                                                input logic [31:0] data);
        store_lane_t s;
        s.be    = 4'b0000;
        s.wdata = data;
        case (mask)
            MASK_LB: begin
                s.be    = 4'b0001 << off;
                s.wdata = {24'b0, data[7:0]} << {off, 3'b000};
            end
            MASK_LH: begin
                s.be    = off[1] ? 4'b1100 : 4'b0011;
                s.wdata = off[1] ? {data[15:0], 16'b0} : {16'b0, data[15:0]};
            end
            MASK_LW: s.be = 4'b1111;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/l1_line_store.sv
// Tag, valid and data arrays of the direct-mapped cache; combinational read,
// byte-enabled per-word write and whole-line tag/valid fill.
module l1_line_store #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 2,
    localparam int SB        = $clog2(SETS),
    localparam int WB        = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SB-1:0]    set_idx,
    input  logic [WB-1:0]    rd_word,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [WB-1:0]    wr_word,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS*LINE_WORDS];

    assign rd_valid = valid_q[set_idx];
    assign rd_tag   = tag_mem[set_idx];
    assign rd_data  = data_mem[{set_idx, rd_word}];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[set_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[set_idx] <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                data_mem[{set_idx, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/l1_dcache_param.sv
// Direct-mapped write-through L1 data cache with multi-word line refill.
// Optional access counters are built when L1_DCACHE_STATS_EN is defined.
//
// state  | meaning
// IDLE   | serve load hits, accept a miss or a store
// REFILL | fetch line words 0..LINE_WORDS-1 from memory, then set tag/valid
// WRITE  | write-through store to memory, merge into line on hit
// DONE   | one cycle with stall low after a store; no new request taken
module l1_dcache_param
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [2:0]        mask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic              stall,
    output logic [31:0]       data_from_cache,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-3:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
`ifdef L1_DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int WB    = $clog2(LINE_WORDS);
    localparam int SB    = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - WB - SB;

    logic [1:0]       a_off;
    logic [WB-1:0]    a_word;
    logic [SB-1:0]    a_set;
    logic [TAG_W-1:0] a_tag;

    assign a_off  = addr[1:0];
    assign a_word = addr[2 +: WB];
    assign a_set  = addr[2+WB +: SB];
    assign a_tag  = addr[ADDR_W-1 -: TAG_W];

    state_t        state_q, state_d;
    logic [WB-1:0] cnt_q, cnt_d;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             st_wr_en;
    logic [WB-1:0]    st_wr_word;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic             fill_en;
    logic             hit;
    logic             last_word;
    store_lane_t      lanes;

    l1_line_store #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_line_store (
        .clk      (clk),
        .reset    (reset),
        .set_idx  (a_set),
        .rd_word  (a_word),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (st_wr_en),
        .wr_word  (st_wr_word),
        .wr_be    (st_be),
        .wr_data  (st_wdata),
        .fill_en  (fill_en),
        .fill_tag (a_tag)
    );

    assign hit       = rd_valid && (rd_tag == a_tag);
    assign last_word = (cnt_q == WB'(LINE_WORDS - 1));
    assign lanes     = store_lanes(mask, a_off, data_in);

    assign data_from_cache = (rd_en && hit) ? load_extract(mask, a_off, rd_data) : 32'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'b0;
        st_wr_en   = 1'b0;
        st_wr_word = a_word;
        st_be      = 4'b0000;
        st_wdata   = 32'b0;
        fill_en    = 1'b0;
        case (state_q)
            IDLE: begin
                stall = (rd_en && !hit) || wr_en;
                if (wr_en) begin
                    state_d = WRITE;
                end else if (rd_en && !hit) begin
                    state_d = REFILL;
                    cnt_d   = '0;
                end
            end
            REFILL: begin
                stall     = 1'b1;
                dmem_req  = 1'b1;
                dmem_addr = {a_tag, a_set, cnt_q};
                if (dmem_ack) begin
                    st_wr_en   = 1'b1;
                    st_wr_word = cnt_q;
                    st_be      = 4'b1111;
                    st_wdata   = dmem_rdata;
                    cnt_d      = cnt_q + WB'(1);
                    if (last_word) begin
                        fill_en = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                stall      = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = 1'b1;
                dmem_addr  = addr[ADDR_W-1:2];
                dmem_be    = lanes.be;
                dmem_wdata = lanes.wdata;
                if (dmem_ack) begin
                    // no-write-allocate: only an already-resident line is updated
                    st_wr_en = hit;
                    st_be    = lanes.be;
                    st_wdata = lanes.wdata;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef L1_DCACHE_STATS_EN
    // The held load re-evaluates as a hit right after its refill; it was
    // already counted as a miss, so that cycle is excluded from hits.
    logic refilled_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            refilled_q <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wr_count   <= '0;
        end else begin
            refilled_q <= (state_q == REFILL) && dmem_ack && last_word;
            if (state_q == IDLE && !wr_en && rd_en && hit && !refilled_q && hit_count != '1) begin
                hit_count <= hit_count + 32'd1;
            end
            if (state_q == IDLE && !wr_en && rd_en && !hit && miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
            if (state_q == IDLE && wr_en && wr_count != '1) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule
